// File: rtl/inception_out18_serializer.sv
// Channel-serial output stage for the 18-output Inception block.
// Buffers whole 18-channel pixel vectors in a small FIFO. Streams them out one channel word per
// beat over valid/ready, with frame position tracking and sticky overflow detection.
module inception_out18_serializer #(
  parameter int unsigned IMG_Width  = 5,
  parameter int unsigned IMG_Height = 5,
  parameter int unsigned Datawidth  = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [Datawidth-1:0] In_0,
  input  logic [Datawidth-1:0] In_1,
  input  logic [Datawidth-1:0] In_2,
  input  logic [Datawidth-1:0] In_3,
  input  logic [Datawidth-1:0] In_4,
  input  logic [Datawidth-1:0] In_5,
  input  logic [Datawidth-1:0] In_6,
  input  logic [Datawidth-1:0] In_7,
  input  logic [Datawidth-1:0] In_8,
  input  logic [Datawidth-1:0] In_9,
  input  logic [Datawidth-1:0] In_10,
  input  logic [Datawidth-1:0] In_11,
  input  logic [Datawidth-1:0] In_12,
  input  logic [Datawidth-1:0] In_13,
  input  logic [Datawidth-1:0] In_14,
  input  logic [Datawidth-1:0] In_15,
  input  logic [Datawidth-1:0] In_16,
  input  logic [Datawidth-1:0] In_17,
  output logic [Datawidth-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_channel,
  output logic                 out_last,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int unsigned NumCh  = 18;
  localparam int unsigned NumPix = IMG_Width * IMG_Height;
  localparam int unsigned PixW   = (NumPix > 1) ? $clog2(NumPix) : 1;
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam logic [PixW-1:0] LastPix = PixW'(NumPix - 1);
  localparam logic [4:0]      LastCh  = 5'd17;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  logic [Datawidth-1:0] in_vec [NumCh];
  logic [Datawidth-1:0] mem_q  [DEPTH][NumCh];

  state_e               state_q;
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q, rd_ptr_inc;
  logic [CntW-1:0]      count_q, count_d;
  logic [4:0]           chan_q;
  logic [PixW-1:0]      pix_q;
  logic                 out_valid_q, out_last_q, frame_done_q, overflow_q;
  logic [Datawidth-1:0] out_data_q, head_next_word;
  logic                 accept, pop, push;

  assign in_vec[0]  = In_0;
  assign in_vec[1]  = In_1;
  assign in_vec[2]  = In_2;
  assign in_vec[3]  = In_3;
  assign in_vec[4]  = In_4;
  assign in_vec[5]  = In_5;
  assign in_vec[6]  = In_6;
  assign in_vec[7]  = In_7;
  assign in_vec[8]  = In_8;
  assign in_vec[9]  = In_9;
  assign in_vec[10] = In_10;
  assign in_vec[11] = In_11;
  assign in_vec[12] = In_12;
  assign in_vec[13] = In_13;
  assign in_vec[14] = In_14;
  assign in_vec[15] = In_15;
  assign in_vec[16] = In_16;
  assign in_vec[17] = In_17;

  // Handshake decode, FIFO occupancy and the first word of the next head pixel.
  always_comb begin
    accept     = out_valid_q && out_ready;
    pop        = accept && (chan_q == LastCh);
    push       = valid_in && ((count_q < CntW'(DEPTH)) || pop);
    rd_ptr_inc = rd_ptr_q + PtrW'(1);
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
    // A vector pushed into a one-deep FIFO on the pop edge is not in memory yet; forward it.
    if (push && (wr_ptr_q == rd_ptr_inc)) begin
      head_next_word = in_vec[0];
    end else begin
      head_next_word = mem_q[rd_ptr_inc][0];
    end
  end

  // Pixel-vector storage: all 18 words written in one cycle.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_vec;
    end
  end

  // FIFO pointers, sticky overflow and the output FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      chan_q       <= '0;
      pix_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      frame_done_q <= 1'b0;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_inc;
      end
      if (valid_in && !push) begin
        overflow_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          out_valid_q <= 1'b0;
          if (count_q != '0) begin
            state_q     <= StSend;
            out_valid_q <= 1'b1;
            chan_q      <= '0;
            out_data_q  <= mem_q[rd_ptr_q][0];
            out_last_q  <= 1'b0;
          end
        end
        StSend: begin
          if (accept) begin
            if (chan_q != LastCh) begin
              chan_q     <= chan_q + 5'd1;
              out_data_q <= mem_q[rd_ptr_q][chan_q + 5'd1];
              out_last_q <= (chan_q == 5'd16) && (pix_q == LastPix);
            end else begin
              chan_q     <= '0;
              out_last_q <= 1'b0;
              if (out_last_q) begin
                pix_q        <= '0;
                frame_done_q <= 1'b1;
              end else begin
                pix_q <= pix_q + PixW'(1);
              end
              if (count_d != '0) begin
                out_data_q <= head_next_word;
              end else begin
                state_q     <= StIdle;
                out_valid_q <= 1'b0;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_channel = chan_q;
  assign out_last    = out_last_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;

endmodule
